// File: rtl/vdp_cpu_bridge_if.sv
// vdp_cpu_bridge_if
//   Request/acknowledge bus between the CPU bridge and the VDP core.
//   master : bridge side  (drives vdp_req, vdp_wrt, vdp_adr, vdp_dbo;
//                          receives vdp_ack, vdp_dbi)
//   slave  : VDP core side (mirror directions)
//   vdp_wrt is 1 for a write and 0 for a read, and is valid while vdp_req
//   is high. vdp_dbi is valid in the cycle that vdp_ack is high.
interface vdp_cpu_bridge_if;
    logic        vdp_req;
    logic        vdp_wrt;
    logic [15:0] vdp_adr;
    logic [7:0]  vdp_dbo;
    logic        vdp_ack;
    logic [7:0]  vdp_dbi;

    modport master (
        output vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
        input  vdp_ack, vdp_dbi
    );

    modport slave (
        input  vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
        output vdp_ack, vdp_dbi
    );
endinterface

// File: rtl/vdp_cpu_bridge.sv
// vdp_cpu_bridge
//   Brings the asynchronous CPU write/read strobes into the VDP pixel clock
//   domain and turns each strobe assertion into exactly one request on the
//   VDP request/acknowledge bus.
//
//   Parameters
//     SYNC_STAGES : synchronizer flops per strobe (2..4)
//     FILTER_LEN  : consecutive equal samples needed to accept a strobe
//                   level change (only with PINFILTER_EN)
//   Ports
//     clk      : VDP pixel clock, rising edge
//     reset_n  : asynchronous active-low reset
//     csw_n    : CPU write strobe, asynchronous, active low
//     csr_n    : CPU read strobe, asynchronous, active low
//     mode     : CPU port select, latched as vdp_adr[1:0]
//     cdo      : CPU write data, latched as vdp_dbo
//     cdi      : last read data, held until the next read acknowledge
//     bus_err  : sticky, set when both strobes are seen active together
//     vdp      : request/acknowledge bus (master modport)
//   Build option
//     PINFILTER_EN : when defined, each synchronized strobe passes a
//                    FILTER_LEN-sample stability filter.
module vdp_cpu_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             csw_n,
    input  logic             csr_n,
    input  logic [1:0]       mode,
    input  logic [7:0]       cdo,
    output logic [7:0]       cdi,
    output logic             bus_err,
    vdp_cpu_bridge_if.master vdp
);

`ifdef PINFILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // Edges after reset until the strobe path reflects the real pins.
    localparam int unsigned PIPE_DEPTH = SYNC_STAGES + (FILTER_EN ? FILTER_LEN : 0);
    localparam int unsigned FLW        = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    logic [SYNC_STAGES-1:0] wsync_q, rsync_q;
    logic                   ws_raw_n, rs_raw_n;
    logic                   ws_n, rs_n;
    logic                   ws, rs;
    logic [FLW-1:0]         flush_q;
    logic                   pipe_ready;

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic       wrt_q, wrt_d;
    logic [1:0] adr_q, adr_d;
    logic [7:0] dbo_q, dbo_d;
    logic [7:0] cdi_q, cdi_d;
    logic       err_q, err_d;
    logic       armed_q, armed_d;

    // Strobe synchronizers, reset to the inactive level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wsync_q <= '1;
            rsync_q <= '1;
        end else begin
            wsync_q <= {wsync_q[SYNC_STAGES-2:0], csw_n};
            rsync_q <= {rsync_q[SYNC_STAGES-2:0], csr_n};
        end
    end

    assign ws_raw_n = wsync_q[SYNC_STAGES-1];
    assign rs_raw_n = rsync_q[SYNC_STAGES-1];

`ifdef PINFILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] wcnt_q, rcnt_q;
    logic           wflt_q, rflt_q;

    // The filtered level flips only after FILTER_LEN consecutive samples
    // that differ from it; any sample equal to it restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
            wflt_q <= 1'b1;
            rflt_q <= 1'b1;
        end else begin
            if (ws_raw_n == wflt_q) begin
                wcnt_q <= '0;
            end else if (wcnt_q == FCW'(FILTER_LEN - 1)) begin
                wflt_q <= ws_raw_n;
                wcnt_q <= '0;
            end else begin
                wcnt_q <= wcnt_q + 1'b1;
            end

            if (rs_raw_n == rflt_q) begin
                rcnt_q <= '0;
            end else if (rcnt_q == FCW'(FILTER_LEN - 1)) begin
                rflt_q <= rs_raw_n;
                rcnt_q <= '0;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end

    assign ws_n = wflt_q;
    assign rs_n = rflt_q;
`else
    assign ws_n = ws_raw_n;
    assign rs_n = rs_raw_n;
`endif

    assign ws = ~ws_n;
    assign rs = ~rs_n;

    // Saturating count of edges since reset; the strobe path is only
    // trusted once its reset value has been flushed out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_q <= '0;
        end else if (!pipe_ready) begin
            flush_q <= flush_q + 1'b1;
        end
    end

    assign pipe_ready = (flush_q == FLW'(PIPE_DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wrt_q   <= 1'b0;
            adr_q   <= '0;
            dbo_q   <= '0;
            cdi_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wrt_q   <= wrt_d;
            adr_q   <= adr_d;
            dbo_q   <= dbo_d;
            cdi_q   <= cdi_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    // armed_q gates new accesses: it is set only once both strobes have been
    // seen inactive through a flushed pipeline, so a strobe held across reset
    // or left over from a simultaneous-strobe error cannot start a request.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wrt_d   = wrt_q;
        adr_d   = adr_q;
        dbo_d   = dbo_q;
        cdi_d   = cdi_q;
        err_d   = err_q;
        armed_d = armed_q;

        case (state_q)
            IDLE: begin
                if (ws && rs) begin
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else if (!armed_q) begin
                    if (pipe_ready && !ws && !rs) begin
                        armed_d = 1'b1;
                    end
                end else if (ws || rs) begin
                    adr_d   = mode;
                    dbo_d   = cdo;
                    wrt_d   = ws;
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (vdp.vdp_ack) begin
                    req_d = 1'b0;
                    wrt_d = 1'b0;
                    if (!wrt_q) begin
                        cdi_d = vdp.vdp_dbi;
                    end
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ws && !rs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vdp.vdp_req = req_q;
    assign vdp.vdp_wrt = wrt_q;
    assign vdp.vdp_adr = {14'b0, adr_q};
    assign vdp.vdp_dbo = dbo_q;
    assign cdi         = cdi_q;
    assign bus_err     = err_q;

endmodule

// File: doc/vdp_cpu_bridge.md
VDP_CPU_BRIDGE -- requirements
Module: vdp_cpu_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per strobe (legal range 2..4).
REQ-002 SHALL have parameter FILTER_LEN, default 3, giving the consecutive equal samples needed to accept a strobe level change (used only with PINFILTER_EN).
REQ-003 SHALL have port clk, input, width 1: the single clock (VDP pixel clock domain); all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, width 1: asynchronous active-low reset.
REQ-005 SHALL have port csw_n, input, width 1: CPU write strobe, asynchronous, active low.
REQ-006 SHALL have port csr_n, input, width 1: CPU read strobe, asynchronous, active low.
REQ-007 SHALL have port mode, input, width 2: CPU port select (VDP port 0..3).
REQ-008 SHALL have port cdo, input, width 8: CPU write data.
REQ-009 SHALL have port cdi, output, width 8: held read data returned to the CPU.
REQ-010 SHALL have port vdp_req, output, width 1: access request to the VDP core.
REQ-011 SHALL have port vdp_wrt, output, width 1: 1 = write, 0 = read; valid while vdp_req is high.
REQ-012 SHALL have port vdp_adr, output, width 16: {14'b0, latched mode}.
REQ-013 SHALL have port vdp_dbo, output, width 8: latched write data.
REQ-014 SHALL have port vdp_ack, input, width 1: VDP acknowledge of the current request.
REQ-015 SHALL have port vdp_dbi, input, width 8: VDP read data, valid in the vdp_ack cycle.
REQ-016 SHALL have port bus_err, output, width 1: sticky flag, set when both strobes are seen active together.

Function
REQ-017 SHALL pass csw_n and csr_n through SYNC_STAGES flops each; the FSM SHALL use only the synchronized (and filtered) strobes ws and rs.
REQ-018 SHALL implement states IDLE, ISSUE, RELEASE.
REQ-019 From IDLE, when exactly one of ws or rs is active: latch mode, cdo and direction, assert vdp_req and vdp_wrt (wrt = ws active), and enter ISSUE.
REQ-020 In IDLE, when ws and rs are both active: issue no request, set bus_err, and stay in IDLE.
REQ-021 In ISSUE, SHALL hold vdp_req, vdp_wrt, vdp_adr and vdp_dbo stable until a cycle with vdp_ack=1.
REQ-022 In that ack cycle: deassert vdp_req and vdp_wrt on the next edge and enter RELEASE; if the access is a read, capture vdp_dbi into cdi.
REQ-023 In RELEASE, SHALL wait until both ws and rs are inactive, then return to IDLE; one CPU strobe SHALL never produce more than one request.
REQ-024 If the strobe deasserts during ISSUE, SHALL complete the pending request (no abort); vdp_ack is still required before leaving ISSUE.
REQ-025 If vdp_ack arrives in the same edge the request is issued, SHALL ignore it; ack is only valid while in ISSUE.
REQ-026 Latency: vdp_req SHALL rise on rising edge SYNC_STAGES+1 after the first edge that samples the strobe low, plus FILTER_LEN edges when the filter is compiled in.
REQ-027 cdi SHALL hold the last read value until the next read ack; writes SHALL NOT change cdi.
REQ-028 bus_err SHALL clear only on reset.

Reset
REQ-029 While reset_n=0, SHALL asynchronously force: FSM to IDLE; vdp_req=0; vdp_wrt=0; vdp_adr=0; vdp_dbo=0; cdi=8'h00; bus_err=0; synchronizer and filter flops to 1 (inactive).
REQ-030 Reset asserted mid-ISSUE SHALL drop vdp_req immediately; after release, a strobe still held low SHALL be treated as a new access only after it has been seen inactive first.

Configuration
REQ-031 Macro PINFILTER_EN defined: each synchronized strobe SHALL pass a FILTER_LEN-sample majority/stability filter, and pulses shorter than FILTER_LEN clocks SHALL be rejected.
REQ-032 Macro PINFILTER_EN undefined: the filter SHALL be absent, the synchronizer output drives the FSM directly, and there SHALL be no FILTER_LEN latency term.

Verification
REQ-033 Write test (SYNC_STAGES=2, no filter): mode=2'b01, cdo=8'h8F, csw_n low for 20 clocks, ack 2 clocks after req -> exactly one req with vdp_wrt=1, vdp_adr=16'h0001, vdp_dbo=8'h8F; req rises at edge 3.
REQ-034 Read test: csr_n low, mode=0, vdp_dbi=8'hA5 with ack -> vdp_wrt=0 during req, and cdi=8'hA5 held after csr_n releases.
REQ-035 Simultaneous strobes: csw_n and csr_n low together -> no vdp_req, bus_err=1, and it stays 1 until reset.
REQ-036 Glitch test with PINFILTER_EN, FILTER_LEN=3: a 2-clock csw_n pulse -> no request; a 3-clock pulse -> exactly one request.
REQ-037 Reset during ISSUE (ack withheld), csw_n still low -> vdp_req=0 immediately; no new request until csw_n goes high and then low again.
